// File: rtl/display_pkg.sv
// Shared display types: digit word array, scan FSM encoding and the helper that
// splits the flat 256-bit digit bus into per-digit words.
package display_pkg;

    localparam int unsigned c_num_digits = 16;
    localparam int unsigned c_digit_w    = 16;
    localparam int unsigned c_idx_w      = $clog2(c_num_digits);

    // One 16-bit 14-segment word per digit; element k is digit k.
    typedef logic [c_num_digits-1:0][c_digit_w-1:0] t_array_slv16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } t_scan_state;

    // Digit k occupies bits [16k+15:16k] of the flat bus.
    function automatic t_array_slv16 unpack_digits(input logic [c_num_digits*c_digit_w-1:0] flat);
        t_array_slv16 words;
        for (int k = 0; k < c_num_digits; k++) begin
            words[k] = flat[c_digit_w*k +: c_digit_w];
        end
        return words;
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-slot dwell timer for the display scan. Counts 0..g_dwell_cycles-1 while
// running and flags the end of the blanking gap and the end of the slot.
// Optional feature: SCAN_PWM_DIM_EN adds a drive-time compare so only the first
// `level` DRIVE cycles of each slot enable the digit.
module scan_slot_timer
    import display_pkg::*;
#(
    parameter int unsigned g_dwell_cycles = 12,
    parameter int unsigned g_blank_cycles = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [3:0]         level,
    output logic               blank_done,
    output logic               slot_done,
    output logic               drive_on
);

    localparam int unsigned c_cnt_w        = $clog2(g_dwell_cycles);
    localparam int unsigned c_drive_cycles = g_dwell_cycles - g_blank_cycles;

    logic [c_cnt_w-1:0] cnt;

    assign blank_done = run && (cnt == c_cnt_w'(g_blank_cycles - 1));
    assign slot_done  = run && (cnt == c_cnt_w'(g_dwell_cycles - 1));

    // Dwell counter: held at 0 while stopped, restarts at 0 at every slot start.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            cnt <= '0;
        end else if (!run || slot_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + c_cnt_w'(1);
        end
    end

`ifdef SCAN_PWM_DIM_EN
    logic [31:0] cnt_ext;
    logic [31:0] level_ext;
    logic [31:0] on_cycles;

    assign cnt_ext   = 32'(cnt);
    assign level_ext = 32'(level);
    // Brightness saturates at the number of DRIVE cycles in a slot.
    assign on_cycles = (level_ext < c_drive_cycles) ? level_ext : c_drive_cycles;
    assign drive_on  = (cnt_ext >= g_blank_cycles) && ((cnt_ext - g_blank_cycles) < on_cycles);
`else
    logic unused_level;

    assign unused_level = ^level;
    assign drive_on     = 1'b1;
`endif

endmodule

// File: rtl/display_scan_sequencer.sv
// Time-multiplexes 16 digit words onto a shared segment bus, one digit per slot,
// with a blanking gap at each slot start so digit enables never overlap.
// Digit words are captured into a shadow at each frame boundary to avoid tearing.
// Optional feature: SCAN_PWM_DIM_EN enables brightness dimming via i_brightness,
// sampled at each frame boundary.
module display_scan_sequencer
    import display_pkg::*;
#(
    parameter int unsigned g_dwell_cycles = 12,
    parameter int unsigned g_blank_cycles = 2
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_enable,
    input  logic [3:0]                            i_brightness,
    input  logic [c_num_digits*c_digit_w-1:0]     i_14seg_cntrls,
    output logic [c_digit_w-1:0]                  o_seg,
    output logic [c_num_digits-1:0]               o_digit_en,
    output logic [c_idx_w-1:0]                    o_digit_idx,
    output logic                                  o_frame_start
);

    t_scan_state        state_q;
    t_scan_state        state_d;
    logic [c_idx_w-1:0] idx_q;
    logic [c_idx_w-1:0] idx_d;
    t_array_slv16       shadow_q;
    logic               frame_start_q;
    logic               load;
    logic               run;
    logic               blank_done;
    logic               slot_done;
    logic               drive_on;
    logic [3:0]         level;

    // Timer only counts while a scan is active and will continue next cycle.
    assign run = i_enable && (state_q != IDLE);

    scan_slot_timer #(
        .g_dwell_cycles (g_dwell_cycles),
        .g_blank_cycles (g_blank_cycles)
    ) u_timer (
        .clk        (i_clk),
        .reset      (i_reset),
        .run        (run),
        .level      (level),
        .blank_done (blank_done),
        .slot_done  (slot_done),
        .drive_on   (drive_on)
    );

    // Next-state logic: disable wins everywhere, otherwise walk BLANK/DRIVE slots.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        if (!i_enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    load    = 1'b1;
                end
                BLANK: begin
                    if (blank_done) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_done) begin
                        state_d = BLANK;
                        // Index wraps 15 -> 0 naturally; that wrap is the frame boundary.
                        idx_d   = idx_q + c_idx_w'(1);
                        load    = (idx_q == c_idx_w'(c_num_digits - 1));
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State, slot index and frame-start pulse registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_start_q <= load;
        end
    end

    // Shadow of the digit words, refreshed only at a frame boundary.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: this register bank is reset even though it is array-like, because
        // its contents reach o_seg and must be defined straight out of reset.
        if (i_reset) begin
            shadow_q <= '0;
        end else if (load) begin
            shadow_q <= unpack_digits(i_14seg_cntrls);
        end
    end

`ifdef SCAN_PWM_DIM_EN
    logic [3:0] bright_q;

    // Brightness is held constant for a whole frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bright_q <= '0;
        end else if (load) begin
            bright_q <= i_brightness;
        end
    end

    assign level = bright_q;
`else
    logic unused_brightness;

    assign unused_brightness = ^i_brightness;
    assign level             = '0;
`endif

    // Outputs decode from registered state, so async reset clears them at once.
    always_comb begin
        o_seg         = '0;
        o_digit_en    = '0;
        o_digit_idx   = idx_q;
        o_frame_start = frame_start_q;
        if (state_q != IDLE) begin
            o_seg = shadow_q[idx_q];
        end
        if ((state_q == DRIVE) && drive_on) begin
            o_digit_en = c_num_digits'(1) << idx_q;
        end
    end

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed bench for display_scan_sequencer with 4-clock slots (1 blank + 3 drive).
// Expected values come from a per-cycle slot/phase formula. PWM dimming cases are
// compiled only when SCAN_PWM_DIM_EN is defined.
module tb_display_scan_sequencer;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [3:0]   brightness;
    logic [255:0] words;
    logic [15:0]  seg;
    logic [15:0]  digit_en;
    logic [3:0]   digit_idx;
    logic         frame_start;

    int n_tests;
    int n_fail;

    display_scan_sequencer #(
        .g_dwell_cycles (4),
        .g_blank_cycles (1)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (enable),
        .i_brightness   (brightness),
        .i_14seg_cntrls (words),
        .o_seg          (seg),
        .o_digit_en     (digit_en),
        .o_digit_idx    (digit_idx),
        .o_frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [255:0] make_words(input logic [15:0] base);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) begin
            w[16*k +: 16] = base | 16'(k);
        end
        return w;
    endfunction

    task automatic check_dark(input string tag);
        check({tag, "_en"},  32'(digit_en),    32'h0);
        check({tag, "_seg"}, 32'(seg),         32'h0);
        check({tag, "_idx"}, 32'(digit_idx),   32'h0);
        check({tag, "_fs"},  32'(frame_start), 32'h0);
    endtask

    // Checks n cycles of scanning from the first BLANK cycle (c=0). Words follow
    // old_base until change_at, after which new_base applies from the next frame.
    task automatic scan_check(input int n, input logic [15:0] old_base, input logic [15:0] new_base,
                              input int change_at, input int n_drive);
        int          slot;
        int          phase;
        int          frame;
        logic [15:0] exp_word;
        logic [15:0] exp_en;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            slot  = (c / 4) % 16;
            phase = c % 4;
            frame = c / 64;
            if (change_at >= 0 && frame > change_at / 64) begin
                exp_word = new_base | 16'(slot);
            end else begin
                exp_word = old_base | 16'(slot);
            end
            exp_en = (phase >= 1 && (phase - 1) < n_drive) ? (16'h0001 << slot) : 16'h0000;
            check("seg",  32'(seg),         32'(exp_word));
            check("en",   32'(digit_en),    32'(exp_en));
            check("idx",  32'(digit_idx),   32'(slot));
            check("fs",   32'(frame_start), (c % 64 == 0) ? 32'h1 : 32'h0);
            if (c == change_at) begin
                words = make_words(new_base);
            end
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        brightness = 4'd15;
        words      = make_words(16'hA500);

        // Reset state, both while held and after release with the scan disabled.
        repeat (2) @(negedge clk);
        check_dark("rst_hold");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_dark("rst_idle");

        // Scan order, blank gaps, frame period, per-digit words, and a mid-frame
        // word change at slot 7 of frame 2 that must only appear in frame 3.
        enable = 1'b1;
        scan_check(220, 16'hA500, 16'h5A00, 128 + 28, 3);

        // Drop enable during DRIVE of slot 5 (c=21 is slot 5, phase 1).
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        scan_check(22, 16'h5A00, 16'h5A00, -1, 3);
        enable = 1'b0;
        @(negedge clk);
        check_dark("dis");
        enable = 1'b1;
        scan_check(8, 16'h5A00, 16'h5A00, -1, 3);

        // c=7 is DRIVE of slot 1: reset mid-DRIVE must clear outputs before any edge.
        #2 rst = 1'b1;
        #1 check_dark("arst");
        @(negedge clk);
        rst = 1'b0;
        scan_check(8, 16'h5A00, 16'h5A00, -1, 3);

`ifdef SCAN_PWM_DIM_EN
        enable     = 1'b0;
        brightness = 4'd1;
        @(negedge clk);
        enable = 1'b1;
        scan_check(16, 16'h5A00, 16'h5A00, -1, 1);

        enable     = 1'b0;
        brightness = 4'd0;
        @(negedge clk);
        enable = 1'b1;
        scan_check(130, 16'h5A00, 16'h5A00, -1, 0);

        enable     = 1'b0;
        brightness = 4'd9;
        @(negedge clk);
        enable = 1'b1;
        scan_check(16, 16'h5A00, 16'h5A00, -1, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
